// File: rtl/axi4_rch_responder.sv
`default_nettype none
// ============================================================================
// Module   : axi4_rch_responder
// Purpose  : AXI4 read-data channel merger. Forwards downstream R beats and
//            injects SLVERR bursts for queued dropped read transactions.
// Revision : 1.0 - initial release
// ============================================================================
module axi4_rch_responder #(
  parameter int C_AXI_ID_WIDTH   = 4,
  parameter int C_AXI_USER_WIDTH = 4,
  parameter int C_AXI_DATA_WIDTH = 64,
  parameter int DROP_FIFO_DEPTH  = 4
) (
  input  logic                        axi4_aclk,
  input  logic                        axi4_arstn,

  input  logic                        drop_valid,
  output logic                        drop_ready,
  input  logic [C_AXI_ID_WIDTH-1:0]   drop_id,
  input  logic [7:0]                  drop_len,
  input  logic [C_AXI_USER_WIDTH-1:0] drop_user,

  input  logic [C_AXI_ID_WIDTH-1:0]   m_axi4_rid,
  input  logic [C_AXI_DATA_WIDTH-1:0] m_axi4_rdata,
  input  logic [1:0]                  m_axi4_rresp,
  input  logic                        m_axi4_rlast,
  input  logic [C_AXI_USER_WIDTH-1:0] m_axi4_ruser,
  input  logic                        m_axi4_rvalid,
  output logic                        m_axi4_rready,

  output logic [C_AXI_ID_WIDTH-1:0]   s_axi4_rid,
  output logic [C_AXI_DATA_WIDTH-1:0] s_axi4_rdata,
  output logic [1:0]                  s_axi4_rresp,
  output logic                        s_axi4_rlast,
  output logic [C_AXI_USER_WIDTH-1:0] s_axi4_ruser,
  output logic                        s_axi4_rvalid,
  input  logic                        s_axi4_rready
);

  localparam int       c_PTR_W  = $clog2(DROP_FIFO_DEPTH);
  localparam logic [1:0] c_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_FWD_BURST = 2'd1,
    ST_ERR       = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  // Drop queue storage; pointers carry one extra wrap bit to separate full from empty
  logic [C_AXI_ID_WIDTH-1:0]   r_fifo_id   [DROP_FIFO_DEPTH];
  logic [7:0]                  r_fifo_len  [DROP_FIFO_DEPTH];
  logic [C_AXI_USER_WIDTH-1:0] r_fifo_user [DROP_FIFO_DEPTH];
  logic [c_PTR_W:0]            r_wptr;
  logic [c_PTR_W:0]            r_rptr;

  logic [7:0]                  r_beat_cnt;
  logic [7:0]                  w_beat_cnt_nxt;

  logic                        w_full;
  logic                        w_empty;
  logic                        w_push;
  logic                        w_pop;
  logic [c_PTR_W-1:0]          w_wr_idx;
  logic [c_PTR_W-1:0]          w_rd_idx;
  logic [C_AXI_ID_WIDTH-1:0]   w_head_id;
  logic [7:0]                  w_head_len;
  logic [C_AXI_USER_WIDTH-1:0] w_head_user;
  logic                        w_err_last;

  assign w_wr_idx = r_wptr[c_PTR_W-1:0];
  assign w_rd_idx = r_rptr[c_PTR_W-1:0];
  assign w_empty  = (r_wptr == r_rptr);
  assign w_full   = (r_wptr[c_PTR_W] != r_rptr[c_PTR_W]) &&
                    (r_wptr[c_PTR_W-1:0] == r_rptr[c_PTR_W-1:0]);

  // Full is judged on the pre-pop occupancy so a pop never frees a slot in the same cycle
  assign drop_ready = ~w_full;
  assign w_push     = drop_valid & ~w_full;

  assign w_head_id   = r_fifo_id[w_rd_idx];
  assign w_head_len  = r_fifo_len[w_rd_idx];
  assign w_head_user = r_fifo_user[w_rd_idx];
  assign w_err_last  = (r_beat_cnt == w_head_len);

  always_ff @(posedge axi4_aclk) begin
    if (w_push) begin
      r_fifo_id[w_wr_idx]   <= drop_id;
      r_fifo_len[w_wr_idx]  <= drop_len;
      r_fifo_user[w_wr_idx] <= drop_user;
    end
  end

  always_ff @(posedge axi4_aclk or negedge axi4_arstn) begin
    if (!axi4_arstn) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
    end
  end

  always_ff @(posedge axi4_aclk or negedge axi4_arstn) begin
    if (!axi4_arstn) begin
      r_state    <= ST_IDLE;
      r_beat_cnt <= 8'd0;
    end else begin
      r_state    <= w_state_nxt;
      r_beat_cnt <= w_beat_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_beat_cnt_nxt = r_beat_cnt;
    w_pop          = 1'b0;
    s_axi4_rid     = m_axi4_rid;
    s_axi4_rdata   = m_axi4_rdata;
    s_axi4_rresp   = m_axi4_rresp;
    s_axi4_rlast   = m_axi4_rlast;
    s_axi4_ruser   = m_axi4_ruser;
    s_axi4_rvalid  = m_axi4_rvalid;
    m_axi4_rready  = s_axi4_rready;

    case (r_state)
      ST_IDLE: begin
        // A pending drop costs one bubble cycle before its error burst starts
        if (!w_empty) begin
          s_axi4_rvalid = 1'b0;
          m_axi4_rready = 1'b0;
          w_state_nxt   = ST_ERR;
        end else if (m_axi4_rvalid && s_axi4_rready && !m_axi4_rlast) begin
          w_state_nxt   = ST_FWD_BURST;
        end
      end

      ST_FWD_BURST: begin
        if (m_axi4_rvalid && s_axi4_rready && m_axi4_rlast) begin
          w_state_nxt = ST_IDLE;
        end
      end

      ST_ERR: begin
        s_axi4_rvalid = 1'b1;
        s_axi4_rid    = w_head_id;
        s_axi4_rdata  = '0;
        s_axi4_rresp  = c_SLVERR;
        s_axi4_rlast  = w_err_last;
        s_axi4_ruser  = w_head_user;
        m_axi4_rready = 1'b0;
        if (s_axi4_rready) begin
          if (w_err_last) begin
            w_pop          = 1'b1;
            w_beat_cnt_nxt = 8'd0;
            w_state_nxt    = ST_IDLE;
          end else begin
            w_beat_cnt_nxt = r_beat_cnt + 8'd1;
          end
        end
      end

      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_axi4_rch_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_axi4_rch_responder
// Purpose  : Self-checking bench: vector table, corner sequences, random run
//            against a queue-based behavioural model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_axi4_rch_responder;

  localparam int IDW   = 4;
  localparam int UW    = 4;
  localparam int DW    = 64;
  localparam int DEPTH = 4;

  logic           clk = 1'b0;
  logic           arstn;
  logic           drop_valid;
  logic           drop_ready;
  logic [IDW-1:0] drop_id;
  logic [7:0]     drop_len;
  logic [UW-1:0]  drop_user;
  logic [IDW-1:0] m_rid;
  logic [DW-1:0]  m_rdata;
  logic [1:0]     m_rresp;
  logic           m_rlast;
  logic [UW-1:0]  m_ruser;
  logic           m_rvalid;
  logic           m_rready;
  logic [IDW-1:0] s_rid;
  logic [DW-1:0]  s_rdata;
  logic [1:0]     s_rresp;
  logic           s_rlast;
  logic [UW-1:0]  s_ruser;
  logic           s_rvalid;
  logic           s_rready;

  always #5 clk = ~clk;

  axi4_rch_responder #(
    .C_AXI_ID_WIDTH  (IDW),
    .C_AXI_USER_WIDTH(UW),
    .C_AXI_DATA_WIDTH(DW),
    .DROP_FIFO_DEPTH (DEPTH)
  ) u_dut (
    .axi4_aclk    (clk),
    .axi4_arstn   (arstn),
    .drop_valid   (drop_valid),
    .drop_ready   (drop_ready),
    .drop_id      (drop_id),
    .drop_len     (drop_len),
    .drop_user    (drop_user),
    .m_axi4_rid   (m_rid),
    .m_axi4_rdata (m_rdata),
    .m_axi4_rresp (m_rresp),
    .m_axi4_rlast (m_rlast),
    .m_axi4_ruser (m_ruser),
    .m_axi4_rvalid(m_rvalid),
    .m_axi4_rready(m_rready),
    .s_axi4_rid   (s_rid),
    .s_axi4_rdata (s_rdata),
    .s_axi4_rresp (s_rresp),
    .s_axi4_rlast (s_rlast),
    .s_axi4_ruser (s_ruser),
    .s_axi4_rvalid(s_rvalid),
    .s_axi4_rready(s_rready)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic           dv;  logic [IDW-1:0] did; logic [7:0] dlen; logic [UW-1:0] duser;
    logic           mv;  logic [IDW-1:0] mid; logic [DW-1:0] mdata; logic [1:0] mresp;
    logic           ml;  logic [UW-1:0]  mu;  logic sr;
    logic           e_dr; logic e_sv; logic e_mr; logic e_chk;
    logic [IDW-1:0] e_id; logic [DW-1:0] e_data; logic [1:0] e_resp; logic e_last; logic [UW-1:0] e_user;
  } vec_t;

  function automatic vec_t mk(
    input logic dv, input logic [IDW-1:0] did, input logic [7:0] dlen, input logic [UW-1:0] duser,
    input logic mv, input logic [IDW-1:0] mid, input logic [DW-1:0] mdata, input logic [1:0] mresp,
    input logic ml, input logic [UW-1:0] mu, input logic sr,
    input logic e_dr, input logic e_sv, input logic e_mr, input logic e_chk,
    input logic [IDW-1:0] e_id, input logic [DW-1:0] e_data, input logic [1:0] e_resp,
    input logic e_last, input logic [UW-1:0] e_user);
    vec_t v;
    v.dv = dv; v.did = did; v.dlen = dlen; v.duser = duser;
    v.mv = mv; v.mid = mid; v.mdata = mdata; v.mresp = mresp; v.ml = ml; v.mu = mu; v.sr = sr;
    v.e_dr = e_dr; v.e_sv = e_sv; v.e_mr = e_mr; v.e_chk = e_chk;
    v.e_id = e_id; v.e_data = e_data; v.e_resp = e_resp; v.e_last = e_last; v.e_user = e_user;
    return v;
  endfunction

  task automatic drive_idle();
    drop_valid = 0; drop_id = '0; drop_len = '0; drop_user = '0;
    m_rvalid = 0; m_rid = '0; m_rdata = '0; m_rresp = '0; m_rlast = 0; m_ruser = '0;
    s_rready = 0;
  endtask

  task automatic do_reset();
    drive_idle();
    arstn = 0;
    repeat (2) @(posedge clk);
    #1 arstn = 1;
  endtask

  typedef struct { logic [IDW-1:0] id; logic [7:0] len; logic [UW-1:0] user; } drop_t;

  vec_t           vt[$];
  logic [IDW-1:0] got[$];
  drop_t          mq[$];
  int             hs;
  bit             done, prev_stall, take;
  logic [IDW-1:0] sv_id;   logic [DW-1:0] sv_data; logic [1:0] sv_resp;
  logic           sv_last; logic [UW-1:0] sv_user;
  // model state: a forwarded burst is open, an error burst is being emitted
  bit             m_fwd, m_err;
  int             m_beat, mode;
  logic           e_dr, e_sv, e_mr, e_last;
  logic [IDW-1:0] e_id;   logic [DW-1:0] e_data; logic [1:0] e_resp; logic [UW-1:0] e_user;

  initial begin
    // reset-time behaviour
    drive_idle();
    arstn = 0;
    m_rvalid = 1; m_rid = 4'h3;
    #1;
    chk("rst s_rvalid", s_rvalid, 1);
    chk("rst s_rid", s_rid, 4'h3);
    chk("rst m_rready", m_rready, 0);
    chk("rst drop_ready", drop_ready, 1);
    s_rready = 1; #1;
    chk("rst m_rready follows", m_rready, 1);

    // vector table: one row per clock cycle, starting in IDLE with the queue empty
    vt.push_back(mk(0,0,0,0, 1,5,64'hDEAD,1,1,2, 1, 1,1,1,1, 5,64'hDEAD,1,1,2)); // single pass-through
    vt.push_back(mk(0,0,0,0, 0,0,0,0,0,0,     0, 1,0,0,1, 0,0,0,0,0));
    vt.push_back(mk(1,3,3,1, 0,0,0,0,0,0,     1, 1,0,1,1, 0,0,0,0,0));           // push {3,3,1}
    vt.push_back(mk(0,0,0,0, 1,6,64'h55,0,0,0, 1, 1,0,0,0, 0,0,0,0,0));          // bubble
    vt.push_back(mk(0,0,0,0, 1,6,64'h55,0,0,0, 1, 1,1,0,1, 3,0,2,0,1));          // err beat 0
    vt.push_back(mk(0,0,0,0, 1,6,64'h55,0,0,0, 0, 1,1,0,1, 3,0,2,0,1));          // stall beat 1
    vt.push_back(mk(0,0,0,0, 1,6,64'h55,0,0,0, 1, 1,1,0,1, 3,0,2,0,1));          // beat 1
    vt.push_back(mk(0,0,0,0, 1,6,64'h55,0,0,0, 1, 1,1,0,1, 3,0,2,0,1));          // beat 2
    vt.push_back(mk(0,0,0,0, 1,6,64'h55,0,0,0, 1, 1,1,0,1, 3,0,2,1,1));          // beat 3 last
    vt.push_back(mk(0,0,0,0, 1,7,64'h10,0,0,4, 1, 1,1,1,1, 7,64'h10,0,0,4));     // fwd beat 0
    vt.push_back(mk(0,0,0,0, 1,7,64'h11,0,0,4, 1, 1,1,1,1, 7,64'h11,0,0,4));     // fwd beat 1
    vt.push_back(mk(1,9,0,3, 1,7,64'h12,0,0,4, 1, 1,1,1,1, 7,64'h12,0,0,4));     // fwd beat 2 + push
    vt.push_back(mk(0,0,0,0, 1,7,64'h13,0,1,4, 1, 1,1,1,1, 7,64'h13,0,1,4));     // fwd beat 3 last
    vt.push_back(mk(0,0,0,0, 1,8,64'h99,0,1,0, 1, 1,0,0,0, 0,0,0,0,0));          // bubble
    vt.push_back(mk(0,0,0,0, 1,8,64'h99,0,1,0, 1, 1,1,0,1, 9,0,2,1,3));          // len0 err beat
    vt.push_back(mk(0,0,0,0, 1,2,64'hAB,3,1,5, 1, 1,1,1,1, 2,64'hAB,3,1,5));     // back to pass-through

    do_reset();
    foreach (vt[i]) begin
      drop_valid = vt[i].dv; drop_id = vt[i].did; drop_len = vt[i].dlen; drop_user = vt[i].duser;
      m_rvalid = vt[i].mv; m_rid = vt[i].mid; m_rdata = vt[i].mdata; m_rresp = vt[i].mresp;
      m_rlast = vt[i].ml; m_ruser = vt[i].mu; s_rready = vt[i].sr;
      @(negedge clk);
      chk($sformatf("vec%0d drop_ready", i), drop_ready, vt[i].e_dr);
      chk($sformatf("vec%0d s_rvalid", i), s_rvalid, vt[i].e_sv);
      chk($sformatf("vec%0d m_rready", i), m_rready, vt[i].e_mr);
      if (vt[i].e_chk) begin
        chk($sformatf("vec%0d s_rid", i), s_rid, vt[i].e_id);
        chk($sformatf("vec%0d s_rdata", i), s_rdata, vt[i].e_data);
        chk($sformatf("vec%0d s_rresp", i), s_rresp, vt[i].e_resp);
        chk($sformatf("vec%0d s_rlast", i), s_rlast, vt[i].e_last);
        chk($sformatf("vec%0d s_ruser", i), s_ruser, vt[i].e_user);
      end
      @(posedge clk); #1;
    end

    // fill the queue while the master stalls; a fifth drop waits for the first pop
    drive_idle();
    for (int k = 1; k <= 4; k++) begin
      drop_valid = 1; drop_id = k[IDW-1:0]; drop_len = 0; drop_user = k[UW-1:0];
      @(negedge clk);
      chk("fill drop_ready", drop_ready, 1);
      @(posedge clk); #1;
    end
    drop_id = 4'd5; drop_user = 4'd5;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("full drop_ready", drop_ready, 0);
      @(posedge clk); #1;
    end
    s_rready = 1; hs = 0; got.delete();
    for (int k = 0; k < 40 && got.size() < 5; k++) begin
      @(negedge clk);
      chk("no accept before pop", drop_ready && (hs == 0), 0);
      take = drop_valid && drop_ready;
      if (s_rvalid && s_rready) begin got.push_back(s_rid); hs++; end
      @(posedge clk); #1;
      if (take) drop_valid = 0;
    end
    chk("fill beat count", got.size(), 5);
    foreach (got[j]) chk($sformatf("fill order %0d", j), got[j], j + 1);

    // len=255 with a toggling master ready
    drive_idle();
    drop_valid = 1; drop_id = 4'hA; drop_len = 8'd255; drop_user = 4'h6;
    @(posedge clk); #1;
    drop_valid = 0; hs = 0; done = 0; prev_stall = 0;
    for (int k = 0; k < 1200 && !done; k++) begin
      s_rready = (k % 2 == 1);
      @(negedge clk);
      if (s_rvalid) begin
        if (prev_stall) begin
          chk("stall rid", s_rid, sv_id);
          chk("stall rdata", s_rdata, sv_data);
          chk("stall rresp", s_rresp, sv_resp);
          chk("stall rlast", s_rlast, sv_last);
          chk("stall ruser", s_ruser, sv_user);
        end
        if (s_rready) begin
          hs++;
          chk($sformatf("len255 rlast at beat %0d", hs), s_rlast, hs == 256);
          if (s_rlast) done = 1;
        end
        prev_stall = !s_rready;
        sv_id = s_rid; sv_data = s_rdata; sv_resp = s_rresp; sv_last = s_rlast; sv_user = s_ruser;
      end else begin
        prev_stall = 0;
      end
      @(posedge clk); #1;
    end
    chk("len255 beats", hs, 256);

    // reset during the second beat of a len=7 error burst
    drive_idle();
    drop_valid = 1; drop_id = 4'h2; drop_len = 8'd7; drop_user = 4'h1; s_rready = 1;
    @(posedge clk); #1;
    drop_valid = 0; hs = 0;
    for (int k = 0; k < 10 && hs == 0; k++) begin
      @(negedge clk);
      if (s_rvalid && s_rresp == 2'b10) hs++;
      @(posedge clk); #1;
    end
    chk("rst setup beat", hs, 1);
    m_rvalid = 1; m_rid = 4'hC;
    #2 arstn = 0;
    #1;
    chk("midrst s_rvalid", s_rvalid, 1);
    chk("midrst s_rid", s_rid, 4'hC);
    chk("midrst m_rready", m_rready, 1);
    chk("midrst drop_ready", drop_ready, 1);
    m_rvalid = 0; #1;
    chk("midrst s_rvalid low", s_rvalid, 0);
    @(posedge clk); #1 arstn = 1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      chk("post-rst no err beat", s_rvalid, 0);
      @(posedge clk); #1;
    end

    // randomized run against the queue model
    do_reset();
    mq.delete(); m_fwd = 0; m_err = 0; m_beat = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      drop_valid = ($urandom_range(0, 3) == 0);
      drop_id    = IDW'($urandom); drop_user = UW'($urandom);
      drop_len   = ($urandom_range(0, 15) == 0) ? 8'($urandom_range(8, 20)) : 8'($urandom_range(0, 3));
      m_rvalid   = ($urandom_range(0, 2) != 0);
      m_rid = IDW'($urandom); m_rdata = {$urandom, $urandom}; m_rresp = 2'($urandom);
      m_rlast    = ($urandom_range(0, 2) == 0); m_ruser = UW'($urandom);
      s_rready   = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      e_dr = (mq.size() < DEPTH);
      if (m_err) begin
        mode = 2; e_sv = 1; e_mr = 0;
        e_id = mq[0].id; e_data = '0; e_resp = 2'b10; e_last = (m_beat == int'(mq[0].len)); e_user = mq[0].user;
      end else if (!m_fwd && mq.size() != 0) begin
        mode = 1; e_sv = 0; e_mr = 0;
        e_id = '0; e_data = '0; e_resp = '0; e_last = 0; e_user = '0;
      end else begin
        mode = 0; e_sv = m_rvalid; e_mr = s_rready;
        e_id = m_rid; e_data = m_rdata; e_resp = m_rresp; e_last = m_rlast; e_user = m_ruser;
      end
      chk("rnd drop_ready", drop_ready, e_dr);
      chk("rnd s_rvalid", s_rvalid, e_sv);
      chk("rnd m_rready", m_rready, e_mr);
      if (mode != 1) begin
        chk("rnd s_rid", s_rid, e_id);
        chk("rnd s_rdata", s_rdata, e_data);
        chk("rnd s_rresp", s_rresp, e_resp);
        chk("rnd s_rlast", s_rlast, e_last);
        chk("rnd s_ruser", s_ruser, e_user);
      end
      @(posedge clk);
      if (mode == 2 && s_rready) begin
        if (e_last) begin
          void'(mq.pop_front());
          m_err = 0; m_beat = 0;
        end else begin
          m_beat++;
        end
      end else if (mode == 1) begin
        m_err = 1;
      end else if (mode == 0 && m_rvalid && s_rready) begin
        m_fwd = !m_rlast;
      end
      if (drop_valid && e_dr) mq.push_back('{id: drop_id, len: drop_len, user: drop_user});
      #1;
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
